// File: rtl/lc3_mem_responder_pkg.sv
// Shared constants for the LC-3 memory responder: device-page addresses,
// FSM state encoding and a small address-decode helper.
package lc3_mem_responder_pkg;

  localparam logic [15:0] DEV_BASE  = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  function automatic logic is_dev_addr(input logic [15:0] addr);
    return addr >= DEV_BASE;
  endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// MAR/MDR bus plus keyboard/display streams between the datapath side
// (master) and the memory responder (slave).
interface lc3_mem_responder_if;

  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_r;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready;
  logic        halt;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata, kb_valid, kb_data, dsp_ready,
    input  mem_rdata, mem_r, kb_ready, dsp_valid, dsp_data, halt
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata, kb_valid, kb_data, dsp_ready,
    output mem_rdata, mem_r, kb_ready, dsp_valid, dsp_data, halt
  );

endinterface

// File: rtl/lc3_mem_responder_mem_array.sv
// Single-port synchronous RAM with registered read.
// Out-of-range addresses read as zero and are never written.
module lc3_mem_array #(
  parameter int    DEPTH     = 65024,
  parameter int    WIDTH     = 16,
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (addr <= LAST) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR bus: fixed-latency access FSM,
// RAM below xFE00 and the keyboard/display/MCR device page above it.
module lc3_mem_responder
  import lc3_mem_responder_pkg::*;
#(
  parameter int    MEM_LATENCY = 2,
  parameter int    MEM_DEPTH   = 65024,
  parameter string INIT_FILE   = ""
) (
  input logic                 clk,
  input logic                 rst,
  lc3_mem_responder_if.slave  bus
);

  localparam logic [15:0] CNT_LAST = 16'(MEM_LATENCY - 2);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] addr_q, wdata_q;
  logic        we_q;
  logic        accept, done, dev, ram_we;
  logic [15:0] ram_addr, ram_rdata, dev_rdata;

  logic        kb_full, kb_ie, dsp_ie, dsp_valid;
  logic [7:0]  kb_byte, dsp_data;
  logic [15:0] mcr;

  assign accept = (state_q == ST_IDLE) && bus.mem_en;
  assign done   = (state_q == ST_DONE);
  assign dev    = is_dev_addr(addr_q);
  assign ram_we = done && we_q && !dev;
  // RAM read is registered: present the live address while idle (covers
  // MEM_LATENCY=1) and the latched one afterwards, so data lands in DONE.
  assign ram_addr = (state_q == ST_IDLE) ? bus.mem_addr : addr_q;

  lc3_mem_array #(
    .DEPTH     (MEM_DEPTH),
    .WIDTH     (16),
    .ADDR_W    (16),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)                   cnt_q <= '0;
      else if (state_q == ST_BUSY)  cnt_q <= cnt_q + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.mem_en) state_d = (MEM_LATENCY <= 1) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture at acceptance; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.mem_addr;
      we_q    <= bus.mem_we;
      wdata_q <= bus.mem_wdata;
    end
  end

  // Device registers and stream handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_full   <= 1'b0;
      kb_byte   <= '0;
      kb_ie     <= 1'b0;
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
      dsp_ie    <= 1'b0;
      mcr       <= 16'h8000;
    end else begin
      if (dsp_valid && bus.dsp_ready) dsp_valid <= 1'b0;
      if (done && dev && !we_q && addr_q == KBDR_ADDR) kb_full <= 1'b0;
      if (done && dev && we_q) begin
        unique case (addr_q)
          KBSR_ADDR: kb_ie  <= wdata_q[14];
          DSR_ADDR:  dsp_ie <= wdata_q[14];
          MCR_ADDR:  mcr    <= wdata_q;
          // A write landing on a completing display handshake still goes in.
          DDR_ADDR: if (!dsp_valid || bus.dsp_ready) begin
            dsp_data  <= wdata_q[7:0];
            dsp_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (bus.kb_valid && !kb_full) begin
        kb_byte <= bus.kb_data;
        kb_full <= 1'b1;
      end
    end
  end

  // Device-page read mux.
  always_comb begin
    dev_rdata = '0;
    unique case (addr_q)
      KBSR_ADDR: dev_rdata = {kb_full, kb_ie, 14'd0};
      KBDR_ADDR: dev_rdata = {8'd0, kb_byte};
      DSR_ADDR:  dev_rdata = {~dsp_valid, dsp_ie, 14'd0};
      MCR_ADDR:  dev_rdata = mcr;
      default:   dev_rdata = '0;
    endcase
  end

  assign bus.mem_r     = done;
  assign bus.mem_rdata = done ? (dev ? dev_rdata : ram_rdata) : '0;
  assign bus.kb_ready  = ~kb_full;
  assign bus.dsp_valid = dsp_valid;
  assign bus.dsp_data  = dsp_data;
  assign bus.halt      = ~mcr[15];

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder with MEM_LATENCY=2.
module tb_lc3_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lc3_mem_responder_if bus();

  lc3_mem_responder #(
    .MEM_LATENCY (2),
    .MEM_DEPTH   (65024),
    .INIT_FILE   ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one access starting #1 after an edge; returns data and cycles to mem_r
  // (0 if mem_r never came). Optionally raises dsp_ready only in the DONE cycle.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic rdy_on_done, output logic [15:0] rdata, output int lat);
    lat   = 0;
    rdata = '0;
    bus.mem_en    = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.mem_r) begin
        lat   = k;
        rdata = bus.mem_rdata;
        break;
      end
    end
    bus.mem_en = 1'b0;
    if (rdy_on_done) bus.dsp_ready = 1'b1;
    @(posedge clk); #1;
    if (rdy_on_done) bus.dsp_ready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] d;
    int lat;
    do_access(1'b1, addr, data, 1'b0, d, lat);
    check_eq({tag, "_lat"}, 16'(lat), 16'd2);
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    int lat;
    do_access(1'b0, addr, 16'h0000, 1'b0, d, lat);
    check_eq({tag, "_lat"}, 16'(lat), 16'd2);
    check_eq(tag, d, exp);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] mask;
    int lat;
    int seen;

    bus.mem_en = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.kb_valid = 1'b0; bus.kb_data = '0; bus.dsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_mem_r",     16'(bus.mem_r),     16'd0);
    check_eq("rst_rdata",     bus.mem_rdata,      16'h0000);
    check_eq("rst_kb_ready",  16'(bus.kb_ready),  16'd1);
    check_eq("rst_dsp_valid", 16'(bus.dsp_valid), 16'd0);
    check_eq("rst_dsp_data",  16'(bus.dsp_data),  16'h0000);
    check_eq("rst_halt",      16'(bus.halt),      16'd0);
    rd("rst_mcr",  16'hFFFE, 16'h8000);
    rd("rst_kbsr", 16'hFE00, 16'h0000);
    rd("rst_dsr",  16'hFE04, 16'h8000);

    // RAM write then read
    wr("ram_wr", 16'h3000, 16'h1234);
    rd("ram_rd", 16'h3000, 16'h1234);
    wr("ram_wr0", 16'h0000, 16'hBEEF);
    rd("ram_rd0", 16'h0000, 16'hBEEF);
    wr("ram_wrtop", 16'hFDFF, 16'hC0DE);
    rd("ram_rdtop", 16'hFDFF, 16'hC0DE);

    // Keyboard
    bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
    @(posedge clk); #1;
    bus.kb_valid = 1'b0;
    check_eq("kb_ready_low", 16'(bus.kb_ready), 16'd0);
    rd("kbsr_full", 16'hFE00, 16'h8000);
    rd("kbdr",      16'hFE02, 16'h0041);
    rd("kbsr_empty", 16'hFE00, 16'h0000);
    check_eq("kb_ready_high", 16'(bus.kb_ready), 16'd1);
    wr("kbsr_ie_wr", 16'hFE00, 16'hFFFF);
    rd("kbsr_ie",    16'hFE00, 16'h4000);
    wr("kbsr_ie_clr", 16'hFE00, 16'h0000);

    // Display
    wr("ddr_wr", 16'hFE06, 16'h0048);
    check_eq("dsp_valid_set", 16'(bus.dsp_valid), 16'd1);
    check_eq("dsp_data_48",   16'(bus.dsp_data),  16'h0048);
    rd("dsr_busy", 16'hFE04, 16'h0000);
    wr("ddr_drop", 16'hFE06, 16'h0049);
    check_eq("dsp_data_kept", 16'(bus.dsp_data), 16'h0048);
    bus.dsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.dsp_ready = 1'b0;
    check_eq("dsp_valid_clr", 16'(bus.dsp_valid), 16'd0);
    rd("dsr_ready", 16'hFE04, 16'h8000);

    // MCR and unmapped device page
    wr("mcr_clr", 16'hFFFE, 16'h0000);
    check_eq("halt_set", 16'(bus.halt), 16'd1);
    rd("mcr_rd0", 16'hFFFE, 16'h0000);
    wr("mcr_set", 16'hFFFE, 16'h8000);
    check_eq("halt_clr", 16'(bus.halt), 16'd0);
    rd("unmapped_rd", 16'hFE10, 16'h0000);
    wr("unmapped_wr", 16'hFE10, 16'hDEAD);
    rd("unmapped_rd2", 16'hFE10, 16'h0000);
    rd("ram_intact", 16'h3000, 16'h1234);
    rd("ram_top_intact", 16'hFDFF, 16'hC0DE);

    // Reset during BUSY abandons the write and resets device registers
    wr("pre_wr", 16'h3001, 16'hAAAA);
    wr("mcr_halt", 16'hFFFE, 16'h0000);
    bus.mem_en = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 16'h3001; bus.mem_wdata = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_en = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.mem_r) seen++;
    end
    rst = 1'b0;
    check_eq("rst_busy_no_r", 16'(seen), 16'd0);
    check_eq("rst_busy_halt", 16'(bus.halt), 16'd0);
    rd("rst_busy_ram", 16'h3001, 16'hAAAA);

    // mem_en held high across three reads
    mask = '0;
    bus.mem_en = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h3000;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (bus.mem_r) begin
        mask[k] = 1'b1;
        check_eq("b2b_data", bus.mem_rdata, 16'h1234);
      end
    end
    bus.mem_en = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_pulses", mask, 16'h0124);

    // DDR write coinciding with display handshake
    wr("ddr_first", 16'hFE06, 16'h0041);
    do_access(1'b1, 16'hFE06, 16'h0042, 1'b1, d, lat);
    check_eq("ddr_hs_lat",   16'(lat),           16'd2);
    check_eq("ddr_hs_valid", 16'(bus.dsp_valid), 16'd1);
    check_eq("ddr_hs_data",  16'(bus.dsp_data),  16'h0042);
    bus.dsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.dsp_ready = 1'b0;
    check_eq("ddr_drain", 16'(bus.dsp_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
